// File: rtl/spi_pkg.sv
// Shared encodings for the SPI master slice: FSM states and {cpol, cpha} mode codes.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

  // Mode codes are {cpol, cpha}.
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_div.sv
// Reloadable down-counter: one-cycle tick every div+1 cycles while enabled.
module spi_clk_div #(
  parameter int unsigned DIV_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                en,
  input  logic [DIV_BITS-1:0] div,
  output logic                tick
);

  logic [DIV_BITS-1:0] reload_q, reload_d;
  logic [DIV_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    reload_d = reload_q;
    cnt_d    = cnt_q;
    if (load) begin
      // The divider is captured here so later changes on div cannot stretch the frame.
      reload_d = div;
      cnt_d    = div;
    end else if (en) begin
      if (cnt_q == '0) begin
        cnt_d = reload_q;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reload_q <= '0;
      cnt_q    <= '0;
    end else begin
      reload_q <= reload_d;
      cnt_q    <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/spi_master_xfer.sv
// Full-duplex SPI master: configurable width, runtime SCK divider, all CPOL/CPHA modes,
// selectable bit order. Frame is IDLE -> SETUP -> XFER -> HOLD -> IDLE.
module spi_master_xfer
  import spi_pkg::*;
#(
  parameter int unsigned BITS      = 8,
  parameter int unsigned DIV_BITS  = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                cpol,
  input  logic                cpha,
  input  logic [DIV_BITS-1:0] div,
  input  logic [BITS-1:0]     tx_data,
  output logic [BITS-1:0]     rx_data,
  output logic                busy,
  output logic                done,
  output logic                sck,
  output logic                cs_n,
  output logic                mosi,
  input  logic                miso
);

  localparam int unsigned     CntW     = $clog2(2 * BITS + 1);
  localparam logic [CntW-1:0] LastEdge = CntW'(2 * BITS);

  spi_state_e      state_q, state_d;
  logic            cpol_q, cpol_d;
  logic            cpha_q, cpha_d;
  logic            sck_q, sck_d;
  logic            cs_n_q, cs_n_d;
  logic            mosi_q, mosi_d;
  logic            done_q, done_d;
  logic [BITS-1:0] rx_q, rx_d;
  logic [BITS-1:0] tx_sh_q, tx_sh_d;
  logic [BITS-1:0] rx_sh_q, rx_sh_d;
  logic [CntW-1:0] edge_q, edge_d;

  logic            tick;
  logic            div_load;
  logic [CntW-1:0] edge_n;
  logic            leading;
  logic            sample_edge;
  logic            drive_edge;

  function automatic logic first_bit(input logic [BITS-1:0] w);
    if (MSB_FIRST) return w[BITS-1];
    else           return w[0];
  endfunction

  function automatic logic [BITS-1:0] shift_out(input logic [BITS-1:0] w);
    if (MSB_FIRST) return {w[BITS-2:0], 1'b0};
    else           return {1'b0, w[BITS-1:1]};
  endfunction

  function automatic logic [BITS-1:0] shift_in(input logic [BITS-1:0] w, input logic b);
    if (MSB_FIRST) return {w[BITS-2:0], b};
    else           return {b, w[BITS-1:1]};
  endfunction

  assign div_load = (state_q == ST_IDLE) && start;

  spi_clk_div #(
    .DIV_BITS(DIV_BITS)
  ) u_clk_div (
    .clk  (clk),
    .reset(reset),
    .load (div_load),
    .en   (state_q != ST_IDLE),
    .div  (div),
    .tick (tick)
  );

  always_comb begin
    state_d     = state_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    sck_d       = sck_q;
    cs_n_d      = cs_n_q;
    mosi_d      = mosi_q;
    done_d      = 1'b0;
    rx_d        = rx_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    edge_d      = edge_q;
    edge_n      = edge_q + 1'b1;
    leading     = edge_n[0];
    sample_edge = leading;

    unique case ({cpol_q, cpha_q})
      MODE0, MODE2: sample_edge = leading;
      MODE1, MODE3: sample_edge = !leading;
      default:      sample_edge = leading;
    endcase
    // CPHA=0 pre-drives the first bit at start, so the final trailing edge has nothing left.
    drive_edge = cpha_q ? leading : (!leading && (edge_n != LastEdge));

    unique case (state_q)
      ST_IDLE: begin
        cpol_d = cpol;
        sck_d  = cpol;
        if (start) begin
          state_d = ST_SETUP;
          cpha_d  = cpha;
          cs_n_d  = 1'b0;
          tx_sh_d = tx_data;
          rx_sh_d = '0;
          edge_d  = '0;
          if (!cpha) begin
            mosi_d  = first_bit(tx_data);
            tx_sh_d = shift_out(tx_data);
          end
        end
      end
      ST_SETUP, ST_XFER: begin
        if (tick) begin
          sck_d   = ~sck_q;
          edge_d  = edge_n;
          state_d = (edge_n == LastEdge) ? ST_HOLD : ST_XFER;
          if (sample_edge) begin
            rx_sh_d = shift_in(rx_sh_q, miso);
          end
          if (drive_edge) begin
            mosi_d  = first_bit(tx_sh_q);
            tx_sh_d = shift_out(tx_sh_q);
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_d = ST_IDLE;
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          rx_d    = rx_sh_q;
          mosi_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      sck_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      rx_q    <= '0;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      edge_q  <= '0;
    end else begin
      state_q <= state_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      sck_q   <= sck_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      rx_q    <= rx_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      edge_q  <= edge_d;
    end
  end

  assign rx_data = rx_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign sck     = sck_q;
  assign cs_n    = cs_n_q;
  assign mosi    = mosi_q;

endmodule
